// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target register port.
package spi_target_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WRITE = 2'd2,
        ST_READ  = 2'd3
    } state_e;

    localparam int         CMD_READ_BIT    = 7;
    localparam logic [7:0] DEFAULT_ID_BYTE = 8'hA5;

endpackage

// File: rtl/spi_target_regs_if.sv
// SPI pins plus the local register bus; slave is the target side, master the host/fabric side.
interface spi_target_regs_if #(
    parameter int ADDR_W = 7
);
    logic              spi_cs_b;
    logic              spi_sck;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata;
    logic              busy;
    logic              frame_abort;

    modport slave (
        input  spi_cs_b, spi_sck, spi_mosi, reg_rdata,
        output spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_we, reg_re, busy, frame_abort
    );

    modport master (
        output spi_cs_b, spi_sck, spi_mosi, reg_rdata,
        input  spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_we, reg_re, busy, frame_abort
    );
endinterface

// File: rtl/spi_pin_sync.sv
// Synchronises the SPI pins into clk and derives SCK edges; flops reset to the idle pin level.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic cs_b_i,
    input  logic sck_i,
    input  logic mosi_i,
    output logic cs_active_o,
    output logic sck_rise_o,
    output logic sck_fall_o,
    output logic mosi_o,
    output logic valid_o
);
    logic [SYNC_STAGES-1:0] cs_q;
    logic [SYNC_STAGES-1:0] sck_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic [SYNC_STAGES-1:0] valid_q;
    logic                   sck_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_q       <= '1;
            sck_q      <= '1;
            mosi_q     <= '1;
            valid_q    <= '0;
            sck_prev_q <= 1'b1;
        end else begin
            cs_q       <= {cs_q[SYNC_STAGES-2:0], cs_b_i};
            sck_q      <= {sck_q[SYNC_STAGES-2:0], sck_i};
            mosi_q     <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
            valid_q    <= {valid_q[SYNC_STAGES-2:0], 1'b1};
            sck_prev_q <= sck_q[SYNC_STAGES-1];
        end
    end

    // valid_o marks when the chain holds real pin samples rather than reset fill
    assign cs_active_o = ~cs_q[SYNC_STAGES-1];
    assign sck_rise_o  = sck_q[SYNC_STAGES-1] & ~sck_prev_q;
    assign sck_fall_o  = ~sck_q[SYNC_STAGES-1] & sck_prev_q;
    assign mosi_o      = mosi_q[SYNC_STAGES-1];
    assign valid_o     = valid_q[SYNC_STAGES-1];
endmodule

// File: rtl/spi_target_regs.sv
// SPI mode-3 target bridging an external host onto an 8-bit register bus.
// IDLE: wait for CS | CMD: command byte, ID out | WRITE: bytes -> reg_we | READ: reg_re, rdata out
module spi_target_regs
    import spi_target_pkg::*;
#(
    parameter int         ADDR_W      = 7,
    parameter logic [7:0] ID_BYTE     = DEFAULT_ID_BYTE,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    spi_target_regs_if.slave bus
);
    logic cs_active, sck_rise, sck_fall, mosi_sync, sync_valid;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
        .clk        (clk),
        .reset      (reset),
        .cs_b_i     (bus.spi_cs_b),
        .sck_i      (bus.spi_sck),
        .mosi_i     (bus.spi_mosi),
        .cs_active_o(cs_active),
        .sck_rise_o (sck_rise),
        .sck_fall_o (sck_fall),
        .mosi_o     (mosi_sync),
        .valid_o    (sync_valid)
    );

    state_e            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        rx_q, rx_d;
    logic [7:0]        tx_q, tx_d;
    logic              miso_q, miso_d;
    logic              byte_done_q, byte_done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              reg_we_q, reg_we_d;
    logic              reg_re_q, reg_re_d;
    logic              rd_cap_q, rd_cap_d;
    logic              abort_q, abort_d;
    logic              armed_q, armed_d;
    logic              frame_on;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 8'h00;
            tx_q        <= 8'h00;
            miso_q      <= 1'b0;
            byte_done_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 8'h00;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            rd_cap_q    <= 1'b0;
            abort_q     <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            byte_done_q <= byte_done_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            rd_cap_q    <= rd_cap_d;
            abort_q     <= abort_d;
            armed_q     <= armed_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        byte_done_d = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        rd_cap_d    = 1'b0;
        abort_d     = 1'b0;
        armed_d     = armed_q;
        frame_on    = (state_q != ST_IDLE) && cs_active;

        // A frame may only start after CS has been seen inactive, so a CS held low through reset is ignored
        if (sync_valid && !cs_active) armed_d = 1'b1;

        if (frame_on && sck_rise) begin
            rx_d        = {rx_q[6:0], mosi_sync};
            bit_cnt_d   = bit_cnt_q + 3'd1;
            byte_done_d = (bit_cnt_q == 3'd7);
        end
        if (frame_on && sck_fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
        end

        if (reg_we_q) addr_d = addr_q + ADDR_W'(1);
        if (frame_on && rd_cap_q) begin
            tx_d   = bus.reg_rdata;
            addr_d = addr_q + ADDR_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (armed_q && cs_active) begin
                    state_d   = ST_CMD;
                    tx_d      = ID_BYTE;
                    bit_cnt_d = 3'd0;
                    miso_d    = 1'b0;
                    armed_d   = 1'b0;
                end
            end
            ST_CMD: begin
                if (byte_done_q) begin
                    addr_d = rx_q[ADDR_W-1:0];
                    if (rx_q[CMD_READ_BIT]) begin
                        state_d  = ST_READ;
                        reg_re_d = 1'b1;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (byte_done_q) begin
                    wdata_d  = rx_q;
                    reg_we_d = 1'b1;
                end
            end
            ST_READ: begin
                rd_cap_d = reg_re_q;
                if (byte_done_q) reg_re_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // A completing byte takes priority; the frame closes on the following clk
        if ((state_q != ST_IDLE) && !cs_active && !byte_done_q) begin
            state_d   = ST_IDLE;
            miso_d    = 1'b0;
            bit_cnt_d = 3'd0;
            rd_cap_d  = 1'b0;
            abort_d   = (bit_cnt_q != 3'd0);
        end
    end

    assign bus.spi_miso    = miso_q;
    assign bus.spi_miso_oe = (state_q != ST_IDLE);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.reg_addr    = addr_q;
    assign bus.reg_wdata   = wdata_q;
    assign bus.reg_we      = reg_we_q;
    assign bus.reg_re      = reg_re_q;
    assign bus.frame_abort = abort_q;
endmodule

// File: tb/tb_spi_target_regs.sv
// Bench for spi_target_regs: table of host frames, scoreboarded register bus, abort and reset corners.
module tb_spi_target_regs;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    spi_target_regs_if #(.ADDR_W(7)) bus ();

    spi_target_regs #(.ADDR_W(7), .ID_BYTE(8'hA5), .SYNC_STAGES(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] d1;
        logic [7:0] d2;
        int         half;
        logic [7:0] m0;
        logic [7:0] m1;
        logic [7:0] m2;
    } vec_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_rd[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         abort_cycles = 0;
    vec_t       vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // Register file model: read data appears one clk after reg_re
    always @(posedge clk) begin
        if (reset) bus.reg_rdata <= 8'h00;
        else if (bus.reg_re) bus.reg_rdata <= {1'b0, bus.reg_addr} ^ 8'h40;
    end

    always @(negedge clk) begin
        wr_t        ew;
        logic [7:0] er;
        if (!reset) begin
            if (bus.frame_abort) abort_cycles++;
            if (bus.reg_we || bus.reg_re)
                check("we_re_exclusive", 32'(bus.reg_we & bus.reg_re), 32'd0);
            if (bus.reg_we) begin
                check("we_expected", 32'(exp_wr.size() > 0), 32'd1);
                if (exp_wr.size() > 0) begin
                    ew = exp_wr.pop_front();
                    check("we_addr", 32'({1'b0, bus.reg_addr}), 32'(ew.addr));
                    check("we_data", 32'(bus.reg_wdata), 32'(ew.data));
                end
            end
            if (bus.reg_re) begin
                check("re_expected", 32'(exp_rd.size() > 0), 32'd1);
                if (exp_rd.size() > 0) begin
                    er = exp_rd.pop_front();
                    check("re_addr", 32'({1'b0, bus.reg_addr}), 32'(er));
                end
            end
        end
    end

    task automatic xfer(input logic [7:0] mo, input int nbits, input int half, input bit last,
                        output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.spi_sck  = 1'b0;
            bus.spi_mosi = mo[7-i];
            #(half);
            mi[7-i] = bus.spi_miso;
            bus.spi_sck = 1'b1;
            if (!(last && i == nbits - 1)) #(half);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_miso"},  32'(bus.spi_miso),    32'd0);
        check({tag, "_oe"},    32'(bus.spi_miso_oe), 32'd0);
        check({tag, "_we"},    32'(bus.reg_we),      32'd0);
        check({tag, "_re"},    32'(bus.reg_re),      32'd0);
        check({tag, "_busy"},  32'(bus.busy),        32'd0);
        check({tag, "_abort"}, 32'(bus.frame_abort), 32'd0);
        check({tag, "_addr"},  32'(bus.reg_addr),    32'd0);
        check({tag, "_wdata"}, 32'(bus.reg_wdata),   32'd0);
    endtask

    task automatic push_expect(input vec_t v);
        logic [6:0] a;
        wr_t        w;
        a = v.cmd[6:0];
        for (int i = 0; i < 3; i++) begin
            if (v.cmd[7]) begin
                exp_rd.push_back({1'b0, a});
            end else if (i < 2) begin
                w.addr = {1'b0, a};
                w.data = (i == 0) ? v.d1 : v.d2;
                exp_wr.push_back(w);
            end
            a = a + 7'd1;
        end
    endtask

    // CS rises one clk after the last SCK rise so the final byte completes as CS drops
    task automatic run_frame(input vec_t v, input string tag);
        logic [7:0] got;
        abort_cycles = 0;
        push_expect(v);
        @(posedge clk);
        #3;
        bus.spi_cs_b = 1'b0;
        #(v.half);
        xfer(v.cmd, 8, v.half, 1'b0, got);
        check({tag, "_miso0"}, 32'(got), 32'(v.m0));
        check({tag, "_busy"},  32'(bus.busy), 32'd1);
        check({tag, "_oe"},    32'(bus.spi_miso_oe), 32'd1);
        xfer(v.d1, 8, v.half, 1'b0, got);
        check({tag, "_miso1"}, 32'(got), 32'(v.m1));
        xfer(v.d2, 8, v.half, 1'b1, got);
        check({tag, "_miso2"}, 32'(got), 32'(v.m2));
        #10;
        bus.spi_cs_b = 1'b1;
        #300;
        check({tag, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
        check({tag, "_rd_left"}, 32'(exp_rd.size()), 32'd0);
        check({tag, "_no_abort"}, 32'(abort_cycles), 32'd0);
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
        exp_wr.delete();
        exp_rd.delete();
    endtask

    initial begin
        logic [7:0] got;
        wr_t        w;

        vecs[0] = '{8'h05, 8'h11, 8'h22, 80, 8'hA5, 8'h00, 8'h00};
        vecs[1] = '{8'h83, 8'h00, 8'h00, 80, 8'hA5, 8'h43, 8'h44};
        vecs[2] = '{8'h7F, 8'hAA, 8'hBB, 80, 8'hA5, 8'h00, 8'h00};
        vecs[3] = '{8'h90, 8'h00, 8'h00, 40, 8'hA5, 8'h50, 8'h51};
        vecs[4] = '{8'hFF, 8'h3C, 8'h00, 40, 8'hA5, 8'h3F, 8'h40};
        vecs[5] = '{8'h20, 8'h5A, 8'hC3, 40, 8'hA5, 8'h00, 8'h00};

        reset        = 1'b1;
        bus.spi_cs_b = 1'b1;
        bus.spi_sck  = 1'b1;
        bus.spi_mosi = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check_reset_vals("post_por");

        for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Abort: CS released after 5 bits of the second data byte
        abort_cycles = 0;
        w.addr = 8'h05;
        w.data = 8'h11;
        exp_wr.push_back(w);
        @(posedge clk);
        #3;
        bus.spi_cs_b = 1'b0;
        #80;
        xfer(8'h05, 8, 80, 1'b0, got);
        xfer(8'h11, 8, 80, 1'b0, got);
        xfer(8'h22, 5, 80, 1'b0, got);
        bus.spi_cs_b = 1'b1;
        #300;
        check("abort_pulse_cycles", 32'(abort_cycles), 32'd1);
        check("abort_wr_left", 32'(exp_wr.size()), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_oe", 32'(bus.spi_miso_oe), 32'd0);
        check("abort_miso", 32'(bus.spi_miso), 32'd0);
        exp_wr.delete();

        // Reset during a READ data byte with CS held low
        abort_cycles = 0;
        exp_rd.push_back(8'h03);
        @(posedge clk);
        #3;
        bus.spi_cs_b = 1'b0;
        #80;
        xfer(8'h83, 8, 80, 1'b0, got);
        xfer(8'h00, 3, 80, 1'b0, got);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("rst_mid");
        check("rst_mid_rd_left", 32'(exp_rd.size()), 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #3;
        xfer(8'hA5, 8, 80, 1'b0, got);
        check_reset_vals("rst_cs_low");
        bus.spi_cs_b = 1'b1;
        #300;
        check("rst_no_abort", 32'(abort_cycles), 32'd0);
        run_frame(vecs[1], "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
